// File: rtl/avg_crossing_detector_pkg.sv
// Shared types for the averaged-signal crossing detector.
// FSM states, event payload and debounce counter width.
package avg_crossing_detector_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    PEND_HIGH = 2'd1,
    HIGH      = 2'd2,
    PEND_LOW  = 2'd3
  } state_t;

  localparam int DB_W   = 8;
  localparam int EVT_TW = 16;

  // tstamp is sized for the widest supported CNT_W
  typedef struct packed {
    logic              rise;
    logic [EVT_TW-1:0] tstamp;
  } evt_t;

endpackage

// File: rtl/avg_crossing_detector_evt_out_reg.sv
// Single-entry valid/ready event holding register.
// A load into a full, unaccepted slot is dropped and flagged.
module evt_out_reg
  import avg_crossing_detector_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  evt_t din,
  input  logic ready,
  output logic valid,
  output evt_t dout,
  output logic overflow
);

  logic xfer;

  assign xfer = valid & ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid    <= 1'b0;
      dout     <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      if (!valid || xfer) begin
        dout  <= din;
        valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/avg_crossing_detector.sv
// Debounced hysteresis crossing detector on the averager output.
// Confirmed crossings leave as timestamped valid/ready events.
module avg_crossing_detector
  import avg_crossing_detector_pkg::*;
#(
  parameter int WL       = 32,
  parameter int CNT_W    = EVT_TW,
  parameter int DEBOUNCE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic signed [WL-1:0] data_in,
  input  logic signed [WL-1:0] th_high,
  input  logic signed [WL-1:0] th_low,
  input  logic                 evt_ready,
  output logic                 evt_valid,
  output logic                 evt_rise,
  output logic [CNT_W-1:0]     evt_time,
  output logic                 level_high,
  output logic                 overflow
);

  localparam logic [DB_W-1:0] DB_N = DB_W'(DEBOUNCE);
  localparam bit DB1 = (DEBOUNCE == 1);

  state_t            st, st_n;
  logic [DB_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0]  idx;
  logic              hi, lo, hit;
  logic              cfm, cfm_rise;
  evt_t              ev_in, ev_q;

  assign hi      = data_in > th_high;
  assign lo      = data_in < th_low;
  assign cnt_inc = cnt + DB_W'(1);
  assign hit     = (cnt_inc == DB_N);

  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    cfm      = 1'b0;
    cfm_rise = 1'b0;
    if (EN) begin
      unique case (st)
        LOW: begin
          if (hi) begin
            if (DB1) begin
              st_n     = HIGH;
              cfm      = 1'b1;
              cfm_rise = 1'b1;
            end else begin
              st_n  = PEND_HIGH;
              cnt_n = DB_W'(1);
            end
          end
        end
        PEND_HIGH: begin
          if (!hi) begin
            st_n  = LOW;
            cnt_n = '0;
          end else if (hit) begin
            st_n     = HIGH;
            cnt_n    = '0;
            cfm      = 1'b1;
            cfm_rise = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        HIGH: begin
          if (lo) begin
            if (DB1) begin
              st_n = LOW;
              cfm  = 1'b1;
            end else begin
              st_n  = PEND_LOW;
              cnt_n = DB_W'(1);
            end
          end
        end
        PEND_LOW: begin
          if (!lo) begin
            st_n  = HIGH;
            cnt_n = '0;
          end else if (hit) begin
            st_n  = LOW;
            cnt_n = '0;
            cfm   = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st         <= LOW;
      cnt        <= '0;
      idx        <= '0;
      level_high <= 1'b0;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      level_high <= (st_n == HIGH) || (st_n == PEND_LOW);
      if (EN) idx <= idx + CNT_W'(1);
    end
  end

  always_comb begin
    ev_in        = '0;
    ev_in.rise   = cfm_rise;
    ev_in.tstamp = EVT_TW'(idx);
  end

  evt_out_reg u_out (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cfm),
    .din      (ev_in),
    .ready    (evt_ready),
    .valid    (evt_valid),
    .dout     (ev_q),
    .overflow (overflow)
  );

  assign evt_rise = ev_q.rise;
  assign evt_time = ev_q.tstamp[CNT_W-1:0];

endmodule

// File: tb/tb_avg_crossing_detector.sv
// Self-checking bench for avg_crossing_detector.
// Table rows plus directed sequences; events checked via a queue.
module tb_avg_crossing_detector;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en  = 1'b0;
  logic signed [31:0] din = '0;
  logic signed [31:0] thh = 32'sd50;
  logic signed [31:0] thl = -32'sd50;
  logic               rdy = 1'b1;
  logic               ev_v, ev_r, lvl, ovf;
  logic [15:0]        ev_t;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rise;
    logic [15:0] t;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic               en;
    logic signed [31:0] d;
    logic               rdy;
    logic               ev;
    logic               lv;
  } vec_t;
  vec_t t1[6];

  always #5 clk = ~clk;

  avg_crossing_detector #(
    .WL(32), .CNT_W(16), .DEBOUNCE(4)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .EN         (en),
    .data_in    (din),
    .th_high    (thh),
    .th_low     (thl),
    .evt_ready  (rdy),
    .evt_valid  (ev_v),
    .evt_rise   (ev_r),
    .evt_time   (ev_t),
    .level_high (lvl),
    .overflow   (ovf)
  );

  // transfer happens on the coming posedge; compare against scoreboard
  always @(negedge clk) begin
    if (!rst && ev_v && rdy) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_evt: got rise=%0b time=%0d, none expected",
                 ev_r, ev_t);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (ev_r !== e.rise || ev_t !== e.t) begin
          n_bad++;
          $display("FAIL evt_payload: got rise=%0b time=%0d, want rise=%0b time=%0d",
                   ev_r, ev_t, e.rise, e.t);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic signed [31:0] d,
                      input logic r);
    en  = e;
    din = d;
    rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic r, input logic [15:0] t);
    exp_t e;
    e.rise = r;
    e.t    = t;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 8 && q.size() > 0; i++) step(1'b0, 0, 1'b1);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d pending events, want 0", nm, q.size());
      q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      t1[i].en  = 1'b1;
      t1[i].d   = 32'sd100;
      t1[i].rdy = 1'b1;
      t1[i].ev  = (i == 3);
      t1[i].lv  = (i >= 3);
    end

    // reset state
    do_reset();
    chk("rst_valid", 32'(ev_v), 0);
    chk("rst_rise",  32'(ev_r), 0);
    chk("rst_time",  32'(ev_t), 0);
    chk("rst_level", 32'(lvl),  0);
    chk("rst_ovf",   32'(ovf),  0);

    // basic rising crossing, table-driven
    push(1'b1, 16'd3);
    for (int i = 0; i < 6; i++) begin
      step(t1[i].en, t1[i].d, t1[i].rdy);
      chk($sformatf("t1_valid%0d", i), 32'(ev_v), 32'(t1[i].ev));
      chk($sformatf("t1_level%0d", i), 32'(lvl),  32'(t1[i].lv));
    end
    drain("t1");

    // mid-sample cancels the pending rise
    do_reset();
    begin
      int s2[8] = '{100, 100, 100, 0, 100, 100, 100, 100};
      for (int i = 0; i < 8; i++) begin
        if (i == 7) push(1'b1, 16'd7);
        step(1'b1, s2[i], 1'b1);
      end
    end
    chk("t2_level", 32'(lvl), 1);
    drain("t2");

    // equal-to-threshold never qualifies, then a falling crossing
    for (int i = 0; i < 5; i++) step(1'b1, -32'sd50, 1'b1);
    chk("t3_level_hold", 32'(lvl), 1);
    chk("t3_no_evt", 32'(ev_v), 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(1'b0, 16'd16);
      step(1'b1, -32'sd51, 1'b1);
    end
    chk("t3_level_low", 32'(lvl), 0);
    drain("t3");

    // overflow while the slot is held
    do_reset();
    push(1'b1, 16'd3);
    for (int i = 0; i < 4; i++) step(1'b1, 32'sd100, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, -32'sd51, 1'b0);
    chk("t4_valid", 32'(ev_v), 1);
    chk("t4_rise",  32'(ev_r), 1);
    chk("t4_time",  32'(ev_t), 3);
    chk("t4_ovf",   32'(ovf),  1);
    step(1'b0, 0, 1'b1);
    chk("t4_valid_clr", 32'(ev_v), 0);
    chk("t4_ovf_stick", 32'(ovf),  1);
    drain("t4");

    // confirm coincides with transfer
    do_reset();
    push(1'b1, 16'd3);
    for (int i = 0; i < 4; i++) step(1'b1, 32'sd100, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, -32'sd51, 1'b0);
    push(1'b0, 16'd7);
    step(1'b1, -32'sd51, 1'b1);
    chk("t5_valid", 32'(ev_v), 1);
    chk("t5_rise",  32'(ev_r), 0);
    chk("t5_time",  32'(ev_t), 7);
    chk("t5_ovf",   32'(ovf),  0);
    drain("t5");

    // reset in the middle of a pending rise
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'sd100, 1'b1);
    rst = 1'b1;
    step(1'b1, 32'sd100, 1'b1);
    rst = 1'b0;
    chk("t6_level", 32'(lvl),  0);
    chk("t6_valid", 32'(ev_v), 0);
    chk("t6_ovf",   32'(ovf),  0);
    chk("t6_time",  32'(ev_t), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'sd100, 1'b1);
    chk("t6_no_evt", 32'(ev_v), 0);
    push(1'b1, 16'd3);
    step(1'b1, 32'sd100, 1'b1);
    chk("t6_evt", 32'(ev_v), 1);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
